// File: rtl/demux_pkg.sv
// demux_pkg: select encodings and output count shared by the 1-to-4 demux blocks.
package demux_pkg;
    localparam logic [1:0] SEL_Y1 = 2'b00;
    localparam logic [1:0] SEL_Y2 = 2'b01;
    localparam logic [1:0] SEL_Y3 = 2'b10;
    localparam logic [1:0] SEL_Y4 = 2'b11;
    localparam int NUM_OUT = 4;
endpackage

// File: rtl/demux1_4_gates.sv
// demux1_4_gates: gate-level 1-to-4 decode core, every data bit routed identically.
// Ports: S2/S1 select (MSB/LSB), A data in, Y1..Y4 decoded data outs (unselected outputs low).
module demux1_4_gates #(
    parameter int WIDTH = 1
) (
    input  logic             S2,
    input  logic             S1,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Y4,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y1
);
    logic w_s2_n;
    logic w_s1_n;
    // Inverted selects are shared by every bit slice.
    not u_not_s2 (w_s2_n, S2);
    not u_not_s1 (w_s1_n, S1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and u_y1 (Y1[i], A[i], w_s2_n, w_s1_n);
        and u_y2 (Y2[i], A[i], w_s2_n, S1);
        and u_y3 (Y3[i], A[i], S2, w_s1_n);
        and u_y4 (Y4[i], A[i], S2, S1);
    end
endmodule

// File: rtl/demux1_4_structural.sv
// demux1_4_structural: registered 1-to-4 demux, structural decode followed by an output register bank.
// Ports: clk rising-edge clock, rst sync active-high clear, S2/S1 select, A data in,
// Y1..Y4 registered outputs (Y1 for select 00 ... Y4 for select 11), one cycle latency.
module demux1_4_structural
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S2,
    input  logic             S1,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Y4,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y1
);
    logic [WIDTH-1:0] w_y1, w_y2, w_y3, w_y4;
    logic [WIDTH-1:0] r_y [NUM_OUT];

    demux1_4_gates #(.WIDTH(WIDTH)) u_gates (
        .S2 (S2),
        .S1 (S1),
        .A  (A),
        .Y4 (w_y4),
        .Y3 (w_y3),
        .Y2 (w_y2),
        .Y1 (w_y1)
    );

    // All four outputs register together, so a select change swaps cleanly on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '{default: '0};
        end else begin
            r_y[SEL_Y1] <= w_y1;
            r_y[SEL_Y2] <= w_y2;
            r_y[SEL_Y3] <= w_y3;
            r_y[SEL_Y4] <= w_y4;
        end
    end

    assign Y1 = r_y[SEL_Y1];
    assign Y2 = r_y[SEL_Y2];
    assign Y3 = r_y[SEL_Y3];
    assign Y4 = r_y[SEL_Y4];
endmodule

// File: tb/tb_demux1_4_structural.sv
// tb_demux1_4_structural: directed and random checks of the registered 1-to-4 demux at WIDTH 1 and 8.
module tb_demux1_4_structural;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s2 = 1'b1;
    logic       s1 = 1'b1;
    logic [7:0] a = 8'hFF;
    logic [7:0] y4w, y3w, y2w, y1w;
    logic       y4n, y3n, y2n, y1n;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    demux1_4_structural #(.WIDTH(8)) u_dut_w (
        .clk (clk), .rst (rst), .S2 (s2), .S1 (s1), .A (a),
        .Y4 (y4w), .Y3 (y3w), .Y2 (y2w), .Y1 (y1w)
    );

    demux1_4_structural u_dut_n (
        .clk (clk), .rst (rst), .S2 (s2), .S1 (s1), .A (a[0]),
        .Y4 (y4n), .Y3 (y3n), .Y2 (y2n), .Y1 (y1n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] wide();
        return {y4w, y3w, y2w, y1w};
    endfunction

    function automatic logic [31:0] narrow();
        return {28'd0, y4n, y3n, y2n, y1n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [7:0] d);
        {s2, s1} = sel;
        a = d;
    endtask

    logic [31:0] exp_w [4] = '{32'h0000_00A5, 32'h0000_A500, 32'h00A5_0000, 32'hA500_0000};
    logic [31:0] exp_n [4] = '{32'h1, 32'h2, 32'h4, 32'h8};

    initial begin
        logic [1:0]  sel_d;
        logic [7:0]  a_d;
        logic [31:0] ew;
        logic [31:0] en;
        // reset holds outputs low despite A=all ones, select 11
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_w", wide(), 32'h0);
            check("reset_n", narrow(), 32'h0);
        end
        rst = 1'b0;
        // select walk
        for (int k = 0; k < 4; k++) begin
            drive(k[1:0], 8'hA5);
            tick();
            check($sformatf("walk%0d_w", k), wide(), exp_w[k]);
            check($sformatf("walk%0d_n", k), narrow(), exp_n[k]);
        end
        // data zero
        for (int k = 0; k < 4; k++) begin
            drive(k[1:0], 8'h00);
            tick();
            check($sformatf("zero%0d_w", k), wide(), 32'h0);
            check($sformatf("zero%0d_n", k), narrow(), 32'h0);
        end
        // latency: select changes between edges, outputs hold until next edge
        drive(2'b00, 8'hFF);
        tick();
        check("lat_pre_w", wide(), 32'h0000_00FF);
        drive(2'b11, 8'hFF);
        @(negedge clk);
        check("lat_hold_w", wide(), 32'h0000_00FF);
        check("lat_hold_n", narrow(), 32'h1);
        tick();
        check("lat_swap_w", wide(), 32'hFF00_0000);
        check("lat_swap_n", narrow(), 32'h8);
        // mid-stream reset
        drive(2'b10, 8'hFF);
        tick();
        check("mid_pre_w", wide(), 32'h00FF_0000);
        rst = 1'b1;
        tick();
        check("mid_rst_w", wide(), 32'h0);
        check("mid_rst_n", narrow(), 32'h0);
        rst = 1'b0;
        tick();
        check("mid_post_w", wide(), 32'h00FF_0000);
        check("mid_post_n", narrow(), 32'h4);
        // random: outputs reflect previous cycle inputs
        for (int c = 0; c < 200; c++) begin
            sel_d = 2'($urandom_range(0, 3));
            a_d = 8'($urandom);
            drive(sel_d, a_d);
            tick();
            ew = 32'h0;
            ew[sel_d*8 +: 8] = a_d;
            en = 32'h0;
            en[sel_d] = a_d[0];
            check("rand_w", wide(), ew);
            check("rand_n", narrow(), en);
            check("rand_or", {24'd0, y1w | y2w | y3w | y4w}, {24'd0, a_d});
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
